// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames bytes from ps2_clk/ps2_data and decodes E0/F0/E1 prefixes into key events.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_kbd_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 2500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

`ifdef PS2_PARITY_CHECK_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   // Abort fires on the TIMEOUT_CYCLES-th consecutive cycle without a sample.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic       clk_s1, clk_s2, clk_s3;
   logic       dat_s1, dat_s2;
   logic       sample;

   state_t     state;
   logic [3:0] count;
   logic [7:0] shreg;
   logic       parity;
   logic       stop;
   logic       ext_pend;
   logic       brk_pend;
   logic [2:0] skip_cnt;
   logic [15:0] idle_cnt;
   logic       frame_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign sample = clk_s3 & ~clk_s2;

   // Odd parity: data plus parity must hold an odd number of ones.
   assign frame_bad = ~stop | (PARITY_EN & ~(^{parity, shreg}));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         shreg    <= '0;
         parity   <= 1'b0;
         stop     <= 1'b0;
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
         skip_cnt <= '0;
         idle_cnt <= '0;
         ps2_key  <= '0;
         err      <= 1'b0;
      end else begin
         ps2_key[10] <= 1'b0;
         err         <= 1'b0;
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (sample && !dat_s2) begin
                  state <= SHIFT;
                  count <= 4'd1;
               end
            end

            SHIFT: begin
               if (sample) begin
                  idle_cnt <= '0;
                  if (count <= 4'd8)
                     shreg <= {dat_s2, shreg[7:1]};
                  else if (count == 4'd9)
                     parity <= dat_s2;
                  if (count == 4'd10) begin
                     stop  <= dat_s2;
                     count <= '0;
                     state <= CHECK;
                  end else begin
                     count <= count + 4'd1;
                  end
               end else if (idle_cnt == TO_LAST) begin
                  state    <= IDLE;
                  count    <= '0;
                  idle_cnt <= '0;
                  err      <= 1'b1;
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
                  skip_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 16'd1;
               end
            end

            CHECK: begin
               state    <= IDLE;
               idle_cnt <= '0;
               if (frame_bad) begin
                  err      <= 1'b1;
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
               end else if (skip_cnt != '0) begin
                  // Pause sequence bytes are swallowed; the last one emits the Pause event.
                  skip_cnt <= skip_cnt - 3'd1;
                  if (skip_cnt == 3'd1) begin
                     ps2_key  <= {1'b1, 1'b0, 1'b1, 8'h77};
                     ext_pend <= 1'b0;
                     brk_pend <= 1'b0;
                  end
               end else begin
                  case (shreg)
                     8'hE0: ext_pend <= 1'b1;
                     8'hF0: brk_pend <= 1'b1;
                     8'hE1: skip_cnt <= 3'd7;
                     8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                     end
                     default: begin
                        ps2_key  <= {1'b1, brk_pend, ext_pend, shreg};
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                     end
                  endcase
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of single-frame vectors plus hand sequences for timing, timeout and reset.
module tb_ps2_kbd_rx;

   localparam int TO   = 200;
   localparam int HALF = 6;

`ifdef PS2_PARITY_CHECK_EN
   localparam int         P_STB = 0;
   localparam int         P_ERR = 1;
   localparam logic [9:0] P_KEY = 10'h37D;
`else
   localparam int         P_STB = 1;
   localparam int         P_ERR = 0;
   localparam logic [9:0] P_KEY = 10'h01C;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_cnt = 0;
   int err_cnt = 0;
   int overlap_cnt = 0;

   ps2_kbd_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (ps2_key[10]) strobe_cnt++;
         if (err) err_cnt++;
         if (ps2_key[10] && err) overlap_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      int         exp_strobes;
      int         exp_errs;
      logic [9:0] exp_key;
   } vec_t;

   vec_t vecs[25];

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic p;
      p = (~^d) ^ bad_par;
      return {~bad_stop, p, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = frame[i];
         wait_clk(HALF);
         ps2_clk = 1'b0;
         wait_clk(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      send_bits(make_frame(d, bad_par, bad_stop), 11);
      ps2_data = 1'b1;
      wait_clk(20);
   endtask

   initial begin
      int s0, e0;
      logic [10:0] f;

      vecs[0]  = '{8'h1C, 0, 0, 1, 0, 10'h01C};
      vecs[1]  = '{8'hE0, 0, 0, 0, 0, 10'h01C};
      vecs[2]  = '{8'hF0, 0, 0, 0, 0, 10'h01C};
      vecs[3]  = '{8'h7D, 0, 0, 1, 0, 10'h37D};
      vecs[4]  = '{8'h1C, 1, 0, P_STB, P_ERR, P_KEY};
      vecs[5]  = '{8'hE0, 0, 0, 0, 0, P_KEY};
      vecs[6]  = '{8'h1C, 0, 1, 0, 1, P_KEY};
      vecs[7]  = '{8'h5A, 0, 0, 1, 0, 10'h05A};
      vecs[8]  = '{8'hE1, 0, 0, 0, 0, 10'h05A};
      vecs[9]  = '{8'h14, 0, 0, 0, 0, 10'h05A};
      vecs[10] = '{8'h77, 0, 0, 0, 0, 10'h05A};
      vecs[11] = '{8'hE1, 0, 0, 0, 0, 10'h05A};
      vecs[12] = '{8'hF0, 0, 0, 0, 0, 10'h05A};
      vecs[13] = '{8'h14, 0, 0, 0, 0, 10'h05A};
      vecs[14] = '{8'hF0, 0, 0, 0, 0, 10'h05A};
      vecs[15] = '{8'h77, 0, 0, 1, 0, 10'h177};
      vecs[16] = '{8'h12, 0, 0, 1, 0, 10'h012};
      vecs[17] = '{8'hAA, 0, 0, 0, 0, 10'h012};
      vecs[18] = '{8'hF0, 0, 0, 0, 0, 10'h012};
      vecs[19] = '{8'hFA, 0, 0, 0, 0, 10'h012};
      vecs[20] = '{8'h34, 0, 0, 1, 0, 10'h034};
      vecs[21] = '{8'hE0, 0, 0, 0, 0, 10'h034};
      vecs[22] = '{8'hF0, 0, 0, 0, 0, 10'h034};
      vecs[23] = '{8'h6B, 0, 0, 1, 0, 10'h36B};
      vecs[24] = '{8'h00, 0, 0, 0, 0, 10'h36B};

      wait_clk(3);
      reset = 1'b0;
      wait_clk(2);
      check("reset_key", 32'(ps2_key), 32'h000);
      check("reset_err", 32'(err), 32'h0);

      for (int i = 0; i < 25; i++) begin
         s0 = strobe_cnt;
         e0 = err_cnt;
         send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
         check($sformatf("vec%0d_strobes", i), 32'(strobe_cnt - s0), 32'(vecs[i].exp_strobes));
         check($sformatf("vec%0d_errs", i), 32'(err_cnt - e0), 32'(vecs[i].exp_errs));
         check($sformatf("vec%0d_key", i), 32'(ps2_key[9:0]), 32'(vecs[i].exp_key));
      end

      // Strobe lands two cycles after the stop-bit sample, which is two cycles after the line falls.
      s0 = strobe_cnt;
      f = make_frame(8'h1C, 0, 0);
      send_bits(f, 10);
      ps2_data = 1'b1;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(3);
      check("timing_early", 32'(ps2_key[10]), 32'h0);
      wait_clk(1);
      check("timing_strobe", 32'(ps2_key[10]), 32'h1);
      check("timing_key", 32'(ps2_key[9:0]), 32'h01C);
      wait_clk(1);
      check("timing_late", 32'(ps2_key[10]), 32'h0);
      ps2_clk = 1'b1;
      wait_clk(20);
      check("timing_count", 32'(strobe_cnt - s0), 32'h1);

      s0 = strobe_cnt;
      e0 = err_cnt;
      send_bits(make_frame(8'h00, 0, 0), 4);
      ps2_data = 1'b1;
      wait_clk(TO + 10);
      check("timeout_err", 32'(err_cnt - e0), 32'h1);
      check("timeout_strobe", 32'(strobe_cnt - s0), 32'h0);
      s0 = strobe_cnt;
      e0 = err_cnt;
      send_frame(8'h29, 0, 0);
      check("after_to_strobe", 32'(strobe_cnt - s0), 32'h1);
      check("after_to_err", 32'(err_cnt - e0), 32'h0);
      check("after_to_key", 32'(ps2_key[9:0]), 32'h029);

      s0 = strobe_cnt;
      e0 = err_cnt;
      send_bits(make_frame(8'h5A, 0, 0), 5);
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      ps2_data = 1'b1;
      wait_clk(2);
      check("midreset_key", 32'(ps2_key), 32'h000);
      send_frame(8'h5A, 0, 0);
      check("midreset_err", 32'(err_cnt - e0), 32'h0);
      check("midreset_strobe", 32'(strobe_cnt - s0), 32'h1);
      check("midreset_key2", 32'(ps2_key[9:0]), 32'h05A);

      check("err_strobe_overlap", 32'(overlap_cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
